// File: rtl/aes_round_sequencer.sv
// AES encryption round sequencer: walks the key-expansion / round opcode
// schedule and hands one opcode at a time to the execute stage over a valid/ready handshake.
module aes_round_sequencer #(
  parameter int NROUNDS = 10,
  parameter int OP_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            op_ready,
  output logic            op_valid,
  output logic [OP_W-1:0] op,
  output logic [1:0]      col,
  output logic [3:0]      round_idx,
  output logic            busy,
  output logic            done
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_ARK, S_KEY_ROT, S_KEY_X0, S_KEY_COL,
    S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  localparam logic [OP_W-1:0] OP_ARK   = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_ROT   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_X0    = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] OP_COL   = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_SHIFT = OP_W'(5'b01011);
  localparam logic [OP_W-1:0] OP_MIX   = OP_W'(5'b01100);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] col_q, col_d;
  logic       hs;

  assign hs = op_valid & op_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    col_d   = col_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_INIT_ARK;
          round_d = 4'd0;
          col_d   = 2'd0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        // abort drops the sequence; an op accepted on this edge does not advance it
        if (abort) begin
          state_d = S_IDLE;
        end else if (hs) begin
          unique case (state_q)
            S_INIT_ARK: begin
              state_d = S_KEY_ROT;
              round_d = round_q + 4'd1;
            end
            S_KEY_ROT: state_d = S_KEY_X0;
            S_KEY_X0: begin
              state_d = S_KEY_COL;
              col_d   = 2'd1;
            end
            S_KEY_COL: begin
              if (col_q == 2'd3) state_d = S_SUB;
              else               col_d   = col_q + 2'd1;
            end
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: state_d = (round_q == LAST_ROUND) ? S_ARK : S_MIX;
            S_MIX:   state_d = S_ARK;
            S_ARK: begin
              if (round_q == LAST_ROUND) begin
                state_d = S_DONE;
              end else begin
                state_d = S_KEY_ROT;
                round_d = round_q + 4'd1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    op_valid  = 1'b1;
    op        = '0;
    col       = 2'd0;
    round_idx = round_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    unique case (state_q)
      S_INIT_ARK, S_ARK: op = OP_ARK;
      S_KEY_ROT:         op = OP_ROT;
      S_KEY_X0:          op = OP_X0;
      S_KEY_COL: begin
        op  = OP_COL;
        col = col_q;
      end
      S_SUB:   op = OP_SUB;
      S_SHIFT: op = OP_SHIFT;
      S_MIX:   op = OP_MIX;
      default: op_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (NROUNDS=10 and 2) share stimulus and are
// checked every cycle against an opcode-list reference model.
module tb_aes_round_sequencer;

  localparam logic [4:0] C_ARK = 5'b00101, C_ROT = 5'b00110, C_X0 = 5'b00111,
                         C_COL = 5'b01000, C_SUB = 5'b01010, C_SHF = 5'b01011,
                         C_MIX = 5'b01100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       op_ready = 1'b1;
  logic       ov  [2];
  logic [4:0] opv [2];
  logic [1:0] colv[2];
  logic [3:0] rdv [2];
  logic       bsy [2];
  logic       dn  [2];

  int n_chk = 0;
  int n_fail = 0;

  logic [10:0] exp_q [2][128];
  int          len     [2];
  int          ptr     [2];
  int          nr      [2];
  bit          running [2];
  bit          dpend   [2];
  logic [3:0]  cur_rd  [2];
  int          hs_obs  [2];
  int          mix_last[2];

  always #5 clk = ~clk;

  aes_round_sequencer #(.NROUNDS(10), .OP_W(5)) u_dut10 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_ready(op_ready),
    .op_valid(ov[0]), .op(opv[0]), .col(colv[0]), .round_idx(rdv[0]),
    .busy(bsy[0]), .done(dn[0]));

  aes_round_sequencer #(.NROUNDS(2), .OP_W(5)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_ready(op_ready),
    .op_valid(ov[1]), .op(opv[1]), .col(colv[1]), .round_idx(rdv[1]),
    .busy(bsy[1]), .done(dn[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic push(input int k, input logic [4:0] o, input logic [1:0] c, input logic [3:0] r);
    exp_q[k][len[k]] = {o, c, r};
    len[k]++;
  endtask

  // Opcode schedule straight from the round structure of AES encryption.
  task automatic build(input int k, input int n);
    len[k] = 0;
    nr[k]  = n;
    push(k, C_ARK, 2'd0, 4'd0);
    for (int r = 1; r <= n; r++) begin
      push(k, C_ROT, 2'd0, 4'(r));
      push(k, C_X0,  2'd0, 4'(r));
      for (int c = 1; c <= 3; c++) push(k, C_COL, 2'(c), 4'(r));
      push(k, C_SUB, 2'd0, 4'(r));
      push(k, C_SHF, 2'd0, 4'(r));
      if (r < n) push(k, C_MIX, 2'd0, 4'(r));
      push(k, C_ARK, 2'd0, 4'(r));
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [10:0] ent;
      if (rst) begin
        running[k] = 0; dpend[k] = 0; ptr[k] = 0; cur_rd[k] = 4'd0;
      end
      chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(running[k] | dpend[k]));
      chk($sformatf("done[%0d]", k), 32'(dn[k]), 32'(dpend[k]));
      chk($sformatf("op_valid[%0d]", k), 32'(ov[k]), 32'(running[k]));
      if (running[k]) begin
        ent = exp_q[k][ptr[k]];
        chk($sformatf("op[%0d]#%0d", k, ptr[k]), 32'(opv[k]), 32'(ent[10:6]));
        chk($sformatf("col[%0d]#%0d", k, ptr[k]), 32'(colv[k]), 32'(ent[5:4]));
        chk($sformatf("round[%0d]#%0d", k, ptr[k]), 32'(rdv[k]), 32'(ent[3:0]));
        cur_rd[k] = ent[3:0];
      end else begin
        chk($sformatf("op_idle[%0d]", k), 32'(opv[k]), 32'd0);
        chk($sformatf("col_idle[%0d]", k), 32'(colv[k]), 32'd0);
        chk($sformatf("round_idle[%0d]", k), 32'(rdv[k]), 32'(cur_rd[k]));
      end
      if (ov[k] && op_ready) hs_obs[k]++;
      if (ov[k] && opv[k] == C_MIX && rdv[k] == 4'(nr[k])) mix_last[k]++;
      if (dn[k]) chk($sformatf("issued[%0d]", k), 32'(hs_obs[k]), 32'(len[k]));
      if (!rst) begin
        if (dpend[k]) dpend[k] = 0;
        else if (running[k]) begin
          if (abort) running[k] = 0;
          else if (op_ready) begin
            ptr[k]++;
            if (ptr[k] == len[k]) begin running[k] = 0; dpend[k] = 1; end
          end
        end else if (start && !abort) begin
          running[k] = 1; ptr[k] = 0; hs_obs[k] = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_idle(input string tag, input bit rnd_ready, input bit rnd_start);
    int t;
    for (t = 0; t < 3000 && (bsy[0] || bsy[1]); t++) begin
      op_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      start    = rnd_start && bsy[0] && !dn[0] && ($urandom_range(0, 2) == 0);
      cyc();
    end
    start = 1'b0; op_ready = 1'b1;
    if (t >= 3000) chk({tag, "_timeout"}, 32'(t), 32'd0);
  endtask

  initial begin
    int c;
    build(0, 10);
    build(1, 2);
    for (int k = 0; k < 2; k++) begin hs_obs[k] = 0; mix_last[k] = 0; end
    #2;
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_busy",  32'(bsy[0]), 32'd0);
    chk("rst_round", 32'(rdv[0]), 32'd0);
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // full run, ready tied high: done lands in cycle 91
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (c = 1; c < 200 && !dn[0]; c++) cyc();
    chk("done_cycle", 32'(c), 32'd91);
    run_to_idle("full", 1'b0, 1'b0);

    // randomized back-pressure runs
    for (int r = 0; r < 4; r++) begin
      start = 1'b1; cyc(); start = 1'b0;
      run_to_idle("rand", 1'b1, 1'b1);
      cyc();
    end

    // stall in SUB of round 3
    start = 1'b1; cyc(); start = 1'b0;
    for (c = 0; c < 300 && !(ov[0] && opv[0] == C_SUB && rdv[0] == 4'd3); c++) cyc();
    chk("reach_sub3", 32'(c < 300), 32'd1);
    op_ready = 1'b0;
    repeat (5) cyc();
    chk("stall_op", 32'(opv[0]), 32'(C_SUB));
    chk("stall_round", 32'(rdv[0]), 32'd3);
    op_ready = 1'b1;
    cyc();
    chk("after_stall", 32'(opv[0]), 32'(C_SHF));
    run_to_idle("stall", 1'b0, 1'b0);

    // abort during KEY_COL col=2, then restart
    start = 1'b1; cyc(); start = 1'b0;
    for (c = 0; c < 300 && !(ov[0] && opv[0] == C_COL && colv[0] == 2'd2); c++) begin
      op_ready = ($urandom_range(0, 1) != 0);
      cyc();
    end
    chk("reach_col2", 32'(c < 300), 32'd1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    chk("abort_valid", 32'(ov[0]), 32'd0);
    chk("abort_done", 32'(dn[0]), 32'd0);
    op_ready = 1'b1;
    run_to_idle("abort1", 1'b0, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_op", 32'(opv[0]), 32'(C_ARK));
    chk("restart_round", 32'(rdv[0]), 32'd0);

    // asynchronous reset mid round 5
    for (c = 0; c < 300 && rdv[0] != 4'd5; c++) cyc();
    chk("reach_r5", 32'(c < 300), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ov[0]), 32'd0);
    chk("arst_op", 32'(opv[0]), 32'd0);
    chk("arst_round", 32'(rdv[0]), 32'd0);
    chk("arst_busy", 32'(bsy[0]), 32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("post_rst_idle", 32'(bsy[0]), 32'd0);

    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    chk("idle_abort_start", 32'(bsy[0]), 32'd0);

    // start pulses while busy are ignored
    start = 1'b1; cyc(); start = 1'b0;
    run_to_idle("ignore_start", 1'b0, 1'b1);
    cyc();

    chk("mix_last10", 32'(mix_last[0]), 32'd0);
    chk("mix_last2", 32'(mix_last[1]), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
